// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the shared-port arbiter and the memory.
// The arbiter uses the slave view; the environment (requesters plus memory) uses the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [3:0]  d_rmask;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [3:0]  mem_rmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, d_rmask, mem_ack, mem_rdata,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, mem_rmask, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, d_rmask, mem_ack, mem_rdata,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, mem_rmask, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch (I) and load/store (D),
// with starvation-limited data priority, a one-cycle done pulse and a hung-access timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [3:0]       rmask_q, rmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             grant_d, grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rmask_q  <= rmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rmask_d  = rmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    // D wins unless I is also waiting and has already lost STARVE_LIM times in a row.
    grant_d  = (state_q == IDLE) && bus.d_req && (!bus.i_req || (starve_q < STARVE_C));
    grant_i  = (state_q == IDLE) && bus.i_req && !grant_d;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant_d) begin
          state_d = BUSY_D;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          wmask_d = bus.d_wmask;
          rmask_d = bus.d_rmask;
          if (bus.i_req && (starve_q != '1)) starve_d = starve_q + 1'b1;
        end else if (grant_i) begin
          state_d  = BUSY_I;
          we_d     = 1'b0;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          rmask_d  = 4'hF;
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack landing on the final timeout cycle still counts as a normal completion.
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : bus.mem_rdata;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE_I, DONE_D: begin
        tmo_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.mem_rmask = rmask_q;

  assign bus.i_done  = (state_q == DONE_I);
  assign bus.i_rdata = (state_q == DONE_I) ? rdata_q : 32'h0;
  assign bus.i_err   = (state_q == DONE_I) && err_q;
  assign bus.d_done  = (state_q == DONE_D);
  assign bus.d_rdata = (state_q == DONE_D) ? rdata_q : 32'h0;
  assign bus.d_err   = (state_q == DONE_D) && err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected memory requests and done responses are queued
// by the stimulus and checked by an independent monitor against a behavioural memory.
module tb_mem_port_arbiter;
  localparam logic [31:0] K = 32'h8C220044;  // memory returns addr ^ K

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIM(4), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [3:0]  rmask;
  } req_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   mem_lat = 0;
  bit   no_ack = 1'b0;
  bit   spur = 1'b0;
  int   bcnt = 0;
  logic prev_req = 1'b0;
  req_t cur_req;
  req_t mon_req;
  rsp_t mon_rsp;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wmask, input logic [3:0] rmask);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask; r.rmask = rmask;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(input logic is_d, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.is_d = is_d; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  // Memory model: acks after mem_lat extra BUSY cycles, or never when no_ack is set.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      bcnt = 0;
    end else begin
      bus.mem_ack   = spur;
      bus.mem_rdata = 32'h5555AAAA;
      if (bus.mem_req) begin
        if (!no_ack && bcnt == mem_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr ^ K;
        end
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
  end

  // Monitor: checks each new memory request, field stability and every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      chk("done_exclusive", {79'h0, bus.i_done & bus.d_done}, 80'h0);
      if (bus.mem_req && !prev_req) begin
        cur_req = mk_req(bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_rmask);
        if (req_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          mon_req = req_q.pop_front();
          chk("mem_request", cur_req, mon_req);
        end
      end else if (bus.mem_req && prev_req) begin
        chk("mem_fields_stable",
            mk_req(bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_rmask), cur_req);
      end
      if (bus.i_done || bus.d_done) begin
        $display("txn %s rdata=%h err=%b", bus.d_done ? "D" : "I",
                 bus.d_done ? bus.d_rdata : bus.i_rdata, bus.d_done ? bus.d_err : bus.i_err);
        if (rsp_q.size() == 0) fail_now("unexpected_done");
        else begin
          mon_rsp = rsp_q.pop_front();
          chk("done_port", {79'h0, bus.d_done}, {79'h0, mon_rsp.is_d});
          chk("done_rdata", bus.d_done ? bus.d_rdata : bus.i_rdata, mon_rsp.rdata);
          chk("done_err", {79'h0, bus.d_done ? bus.d_err : bus.i_err}, {79'h0, mon_rsp.err});
        end
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int n, input int budget, output int cycles);
    int seen = 0;
    cycles = 0;
    while (seen < n && cycles < budget) begin
      tick();
      cycles++;
      if (bus.i_done || bus.d_done) seen++;
    end
    if (seen < n) fail_now("wait_done_bound");
  endtask

  // Contention pattern with STARVE_LIM=4: four D grants, then one I grant, repeating.
  task automatic push_mix(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 5 == 4) begin
        req_q.push_back(mk_req(1'b0, 32'h40, 32'h0, 4'h0, 4'hF));
        rsp_q.push_back(mk_rsp(1'b0, 32'h8C220004, 1'b0));
      end else begin
        req_q.push_back(mk_req(1'b0, 32'h200, 32'h0, 4'h0, 4'hF));
        rsp_q.push_back(mk_rsp(1'b1, 32'h8C220244, 1'b0));
      end
    end
  endtask

  task automatic drive_both();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'h0; bus.d_rmask = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_wmask = 4'h0; bus.d_rmask = 4'h0;
    tick(); tick();
    chk("reset_outputs",
        {bus.busy, bus.mem_req, bus.i_done, bus.d_done, bus.i_err, bus.d_err, bus.mem_we,
         bus.mem_addr, bus.mem_wmask, bus.mem_rmask}, 80'h0);
    rst = 1'b0;
    tick();

    // Single fetch, ack in the first BUSY cycle.
    mem_lat = 0;
    req_q.push_back(mk_req(1'b0, 32'h40, 32'h0, 4'h0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b0, 32'h8C220004, 1'b0));
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    tick();
    chk("fetch_mem_req_cycle1", {79'h0, bus.mem_req}, 80'h1);
    tick();
    chk("fetch_done_cycle2", {79'h0, bus.i_done}, 80'h1);
    bus.i_req = 1'b0;
    tick();
    chk("fetch_idle_cycle3", {79'h0, bus.busy}, 80'h0);

    // Store with ack in the third BUSY cycle.
    mem_lat = 2;
    req_q.push_back(mk_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, 4'h0));
    rsp_q.push_back(mk_rsp(1'b1, 32'h0, 1'b0));
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEADBEEF; bus.d_wmask = 4'b0011; bus.d_rmask = 4'h0;
    wait_dones(1, 40, c);
    chk("store_latency", c, 4);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 32'h0; bus.d_wmask = 4'h0;
    tick(); tick();

    // Load that never gets acked: aborted after 16 BUSY cycles.
    no_ack = 1'b1;
    req_q.push_back(mk_req(1'b0, 32'h300, 32'h0, 4'h0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, 32'h0, 1'b1));
    bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_rmask = 4'hF;
    wait_dones(1, 40, c);
    chk("timeout_latency", c, 17);
    bus.d_req = 1'b0;
    no_ack = 1'b0;
    tick();

    // Fetch after the timeout is served normally.
    mem_lat = 0;
    req_q.push_back(mk_req(1'b0, 32'h44, 32'h0, 4'h0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b0, 32'h8C220000, 1'b0));
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    wait_dones(1, 40, c);
    chk("after_timeout_latency", c, 2);
    bus.i_req = 1'b0;
    tick();

    // Ack on the exact timeout cycle completes normally.
    mem_lat = 15;
    req_q.push_back(mk_req(1'b0, 32'h304, 32'h0, 4'h0, 4'hF));
    rsp_q.push_back(mk_rsp(1'b1, 32'h8C220340, 1'b0));
    bus.d_req = 1'b1; bus.d_addr = 32'h304; bus.d_rmask = 4'hF;
    wait_dones(1, 40, c);
    chk("ack_on_timeout_latency", c, 17);
    bus.d_req = 1'b0;
    tick(); tick();

    // Spurious ack while idle.
    mem_lat = 0;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spurious_ack_idle", {77'h0, bus.busy, bus.i_done, bus.d_done}, 80'h0);
    tick();
    chk("spurious_ack_after", {77'h0, bus.busy, bus.i_done, bus.d_done}, 80'h0);

    // Continuous contention: D,D,D,D,I,D,D,D,D,I.
    push_mix(10);
    drive_both();
    wait_dones(10, 100, c);
    chk("contention_cycles", c, 29);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();

    // Build starvation to 4 with a hung fourth D access, then reset mid-BUSY_D.
    for (int k = 0; k < 4; k++) req_q.push_back(mk_req(1'b0, 32'h200, 32'h0, 4'h0, 4'hF));
    for (int k = 0; k < 3; k++) rsp_q.push_back(mk_rsp(1'b1, 32'h8C220244, 1'b0));
    drive_both();
    wait_dones(3, 40, c);
    chk("pre_reset_cycles", c, 8);
    no_ack = 1'b1;
    tick(); tick(); tick();
    chk("pre_reset_busy", {79'h0, bus.busy}, 80'h1);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_mem_req", {79'h0, bus.mem_req}, 80'h0);
    chk("async_reset_busy", {79'h0, bus.busy}, 80'h0);
    tick(); tick();
    rst = 1'b0;
    no_ack = 1'b0;
    // Starvation count was cleared, so D wins four more times before I.
    push_mix(5);
    wait_dones(5, 60, c);
    chk("post_reset_cycles", c, 14);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick(); tick();
    chk("req_queue_drained", req_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
